// File: rtl/ay_note_writer.sv
// Note-event front end for the three AY-3-8910/YM2149 tone channels: looks up the
// tone period, keeps the mixer shadow and sequences register writes over BDIR/BC1/DA.
module ay_note_writer #(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_note_on,
    input  logic [1:0]  ev_chan,
    input  logic [6:0]  ev_note,
    input  logic [6:0]  ev_vel,
    output logic [6:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [7:0]  ay_da,
    output logic        ay_bdir,
    output logic        ay_bc1,
    output logic        busy
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    localparam logic [2:0] PH_START = 3'd0;
    localparam logic [2:0] PH_LATCH = 3'd1;
    localparam logic [2:0] PH_GAP1  = 3'd2;
    localparam logic [2:0] PH_DATA  = 3'd3;
    localparam logic [2:0] PH_GAP2  = 3'd4;

    localparam logic [1:0] CMD_INIT = 2'd0;
    localparam logic [1:0] CMD_OFF  = 2'd1;
    localparam logic [1:0] CMD_ON   = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    logic [1:0]  state;
    logic [2:0]  phase;
    logic [7:0]  cnt;
    logic [1:0]  idx;
    logic [1:0]  cmd;
    logic [1:0]  chan;
    logic [3:0]  vel_hi;
    logic [11:0] period;
    logic [2:0]  tone_off;

    logic [7:0]  mixer;
    logic [15:0] cur_entry;
    logic [15:0] nxt_entry;
    logic [1:0]  last_idx;

    // One (reg, data) pair of the active command list, selected by position.
    function automatic logic [15:0] list_entry(
        input logic [1:0]  c_cmd,
        input logic [1:0]  i,
        input logic [1:0]  c,
        input logic [11:0] p,
        input logic [3:0]  v,
        input logic [7:0]  mix
    );
        logic [7:0] ch8;
        logic [15:0] e;
        ch8 = {6'd0, c};
        e = 16'h0000;
        case (c_cmd)
            CMD_INIT: e = {8'd7 + {6'd0, i}, (i == 2'd0) ? 8'h3F : 8'h00};
            CMD_OFF:  e = {8'd8 + ch8, 8'h00};
            default: begin
                case (i)
                    2'd0:    e = {ch8[6:0], 1'b0, p[7:0]};
                    2'd1:    e = {ch8[6:0], 1'b1, 4'h0, p[11:8]};
                    2'd2:    e = {8'd8 + ch8, 4'h0, v};
                    default: e = {8'd7, mix};
                endcase
            end
        endcase
        return e;
    endfunction

    // Noise disables stay set and the top two bits stay clear, so only tone bits are stored.
    always_comb begin
        mixer     = {5'b00111, tone_off};
        cur_entry = list_entry(cmd, idx, chan, period, vel_hi, mixer);
        nxt_entry = list_entry(cmd, idx + 2'd1, chan, period, vel_hi, mixer);
        last_idx  = (cmd == CMD_OFF) ? 2'd0 : 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            phase    <= PH_START;
            cnt      <= 8'd0;
            idx      <= 2'd0;
            cmd      <= CMD_INIT;
            chan     <= 2'd0;
            vel_hi   <= 4'd0;
            period   <= 12'd0;
            tone_off <= 3'b111;
            rom_addr <= 7'd0;
            ay_da    <= 8'd0;
            ay_bdir  <= 1'b0;
            ay_bc1   <= 1'b0;
            ev_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Channel 3 events are swallowed here without leaving IDLE.
                    if (ev_valid && ev_ready && ev_chan != 2'd3) begin
                        chan     <= ev_chan;
                        vel_hi   <= ev_vel[6:3];
                        idx      <= 2'd0;
                        ev_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (ev_note_on && ev_vel != 7'd0) begin
                            cmd      <= CMD_ON;
                            rom_addr <= ev_note;
                            state    <= ST_LOOKUP;
                        end else begin
                            cmd     <= CMD_OFF;
                            state   <= ST_WRITE;
                            phase   <= PH_LATCH;
                            cnt     <= HOLD_LAST;
                            ay_da   <= 8'd8 + {6'd0, ev_chan};
                            ay_bdir <= 1'b1;
                            ay_bc1  <= 1'b1;
                        end
                    end
                end
                ST_LOOKUP: begin
                    period         <= rom_data;
                    tone_off[chan] <= 1'b0;
                    state          <= ST_WRITE;
                    phase          <= PH_LATCH;
                    cnt            <= HOLD_LAST;
                    ay_da          <= cur_entry[15:8];
                    ay_bdir        <= 1'b1;
                    ay_bc1         <= 1'b1;
                end
                default: begin
                    case (phase)
                        PH_START: begin
                            phase   <= PH_LATCH;
                            cnt     <= HOLD_LAST;
                            ay_da   <= cur_entry[15:8];
                            ay_bdir <= 1'b1;
                            ay_bc1  <= 1'b1;
                        end
                        PH_LATCH: begin
                            if (cnt == 8'd0) begin
                                ay_bdir <= 1'b0;
                                ay_bc1  <= 1'b0;
                                phase   <= PH_GAP1;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                        PH_GAP1: begin
                            ay_da   <= cur_entry[7:0];
                            ay_bdir <= 1'b1;
                            ay_bc1  <= 1'b0;
                            phase   <= PH_DATA;
                            cnt     <= HOLD_LAST;
                        end
                        PH_DATA: begin
                            if (cnt == 8'd0) begin
                                ay_bdir <= 1'b0;
                                phase   <= PH_GAP2;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                        default: begin
                            if (idx == last_idx) begin
                                state    <= ST_IDLE;
                                phase    <= PH_START;
                                ev_ready <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                idx     <= idx + 2'd1;
                                phase   <= PH_LATCH;
                                cnt     <= HOLD_LAST;
                                ay_da   <= nxt_entry[15:8];
                                ay_bdir <= 1'b1;
                                ay_bc1  <= 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ay_note_writer.sv
// Self-checking bench for ay_note_writer: a bus monitor decodes chip writes and
// compares them against a scoreboard queue filled when events are driven.
module tb_ay_note_writer;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic        ev_note_on = 1'b0;
    logic [1:0]  ev_chan = 2'd0;
    logic [6:0]  ev_note = 7'd0;
    logic [6:0]  ev_vel = 7'd0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [7:0]  ay_da;
    logic        ay_bdir;
    logic        ay_bc1;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        note_on;
        logic [1:0]  chan;
        logic [6:0]  note;
        logic [6:0]  vel;
        int          n;
        logic [15:0] w0, w1, w2, w3;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    ay_note_writer #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_note_on(ev_note_on), .ev_chan(ev_chan), .ev_note(ev_note), .ev_vel(ev_vel),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ay_da(ay_da), .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bench-side note-period ROM contents for the notes used below.
    function automatic logic [11:0] rom_fn(input logic [6:0] a);
        case (a)
            7'd69:   return 12'd249;
            7'd22:   return 12'd3754;
            7'd60:   return 12'h910;
            7'd127:  return 12'h2BF;
            default: return 12'h123;
        endcase
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Bus monitor: rebuilds (reg, data) writes and checks phase lengths and gaps.
    int          mon_ph = 0;
    int          lat_len = 0;
    int          dat_len = 0;
    logic        have_reg = 1'b0;
    logic [7:0]  lat_reg = 8'd0;
    logic [7:0]  dat_val = 8'd0;
    logic [15:0] popped;

    always @(negedge clk) begin
        if (rst) begin
            mon_ph   = 0;
            have_reg = 1'b0;
        end else begin
            case ({ay_bdir, ay_bc1})
                2'b11: begin
                    if (mon_ph == 1) lat_len++;
                    else begin
                        if (mon_ph == 2) checkOutput("gap_before_latch", {30'd0, ay_bdir, ay_bc1}, 32'd0);
                        mon_ph  = 1;
                        lat_reg = ay_da;
                        lat_len = 1;
                    end
                end
                2'b10: begin
                    if (mon_ph == 2) dat_len++;
                    else begin
                        if (mon_ph == 1) checkOutput("gap_before_data", {30'd0, ay_bdir, ay_bc1}, 32'd0);
                        else checkOutput("latch_before_data", {31'd0, have_reg}, 32'd1);
                        mon_ph  = 2;
                        dat_val = ay_da;
                        dat_len = 1;
                    end
                end
                2'b00: begin
                    if (mon_ph == 1) begin
                        checkOutput("latch_len", lat_len, HOLD);
                        checkOutput("gap1_da_held", {24'd0, ay_da}, {24'd0, lat_reg});
                        have_reg = 1'b1;
                        mon_ph   = 0;
                    end else if (mon_ph == 2) begin
                        checkOutput("data_len", dat_len, HOLD);
                        checkOutput("gap2_da_held", {24'd0, ay_da}, {24'd0, dat_val});
                        if (exp_q.size() == 0) checkOutput("sb_pending", exp_q.size(), 1);
                        else begin
                            popped = exp_q.pop_front();
                            checkOutput("write", {16'd0, lat_reg, dat_val}, {16'd0, popped});
                        end
                        have_reg = 1'b0;
                        mon_ph   = 0;
                    end
                end
                default: checkOutput("bus_code", {30'd0, ay_bdir, ay_bc1}, 32'd0);
            endcase
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_da"}, {24'd0, ay_da}, 32'd0);
        checkOutput({tag, "_bus"}, {30'd0, ay_bdir, ay_bc1}, 32'd0);
        checkOutput({tag, "_ready"}, {31'd0, ev_ready}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_rom_addr"}, {25'd0, rom_addr}, 32'd0);
    endtask

    // Called at a negedge with rst high: releases reset and expects the INIT list.
    task automatic runInit(input string tag);
        int k;
        exp_q.push_back(16'h073F);
        exp_q.push_back(16'h0800);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0A00);
        rst = 1'b0;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!ev_ready && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        checkOutput({tag, "_ready_latency"}, k, 40);
        checkOutput({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // Called at a negedge: drives one event, scrambles inputs after accept, checks latency.
    task automatic applyStimulus(input vec_t v, input int id);
        int k;
        if (v.n >= 1) exp_q.push_back(v.w0);
        if (v.n == 4) begin
            exp_q.push_back(v.w1);
            exp_q.push_back(v.w2);
            exp_q.push_back(v.w3);
        end
        ev_valid   = 1'b1;
        ev_note_on = v.note_on;
        ev_chan    = v.chan;
        ev_note    = v.note;
        ev_vel     = v.vel;
        @(posedge clk);
        #1;
        ev_valid   = 1'b0;
        ev_note_on = ~v.note_on;
        ev_chan    = v.chan + 2'd1;
        ev_note    = 7'($urandom_range(0, 127));
        ev_vel     = 7'($urandom_range(0, 127));
        k = 0;
        @(negedge clk);
        if (v.n == 4) checkOutput($sformatf("v%0d_rom_addr", id), {25'd0, rom_addr}, {25'd0, v.note});
        while (!ev_ready && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        checkOutput($sformatf("v%0d_latency", id), k, v.lat);
        checkOutput($sformatf("v%0d_busy", id), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("v%0d_sb_drained", id), exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t midv;
        vecs[0] = '{1'b1, 2'd0, 7'd69,  7'd127, 4, 16'h00F9, 16'h0100, 16'h080F, 16'h073E, 41};
        vecs[1] = '{1'b1, 2'd2, 7'd22,  7'd64,  4, 16'h04AA, 16'h050E, 16'h0A08, 16'h073A, 41};
        vecs[2] = '{1'b0, 2'd0, 7'd69,  7'd100, 1, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 10};
        vecs[3] = '{1'b1, 2'd1, 7'd50,  7'd0,   1, 16'h0900, 16'h0000, 16'h0000, 16'h0000, 10};
        vecs[4] = '{1'b1, 2'd3, 7'd10,  7'd100, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[5] = '{1'b1, 2'd1, 7'd60,  7'd40,  4, 16'h0210, 16'h0309, 16'h0905, 16'h0738, 41};
        vecs[6] = '{1'b0, 2'd2, 7'd0,   7'd0,   1, 16'h0A00, 16'h0000, 16'h0000, 16'h0000, 10};
        vecs[7] = '{1'b1, 2'd0, 7'd127, 7'd8,   4, 16'h00BF, 16'h0102, 16'h0801, 16'h0738, 41};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("por");
        runInit("por");

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Reset during the DATA phase of the amplitude write of a note-on.
        $display("[TB] reset during amplitude write");
        midv = '{1'b1, 2'd1, 7'd60, 7'd127, 2, 16'h0210, 16'h0309, 16'h0000, 16'h0000, 0};
        exp_q.push_back(midv.w0);
        exp_q.push_back(midv.w1);
        ev_valid   = 1'b1;
        ev_note_on = midv.note_on;
        ev_chan    = midv.chan;
        ev_note    = midv.note;
        ev_vel     = midv.vel;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        repeat (27) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_data_phase", {22'd0, ay_bdir, ay_bc1, ay_da}, {22'd0, 2'b10, 8'h0F});
        checkOutput("mid_first_writes_done", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("mid");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        runInit("mid");

        // Mixer shadow must be back at 0x3F, so chan 0 note-on writes 0x3E.
        applyStimulus(vecs[0], 8);

        repeat (5) @(negedge clk);
        checkOutput("final_sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
